// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver. It shows frame-coherent digit snapshots,
// inserts an anti-ghost blank window at the start of every slot, and blinks edited digits.
module seg7_scan_driver #(
  parameter int N_DIGITS       = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [4*N_DIGITS-1:0]   digits_bcd,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blink_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_tick
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0]       SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0]       BLANK_END  = SW'(BLANK_CYCLES);
  localparam logic [DW-1:0]       DIGIT_LAST = DW'(N_DIGITS - 1);
  localparam logic [FW-1:0]       FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [N_DIGITS-1:0] AN_ONE     = N_DIGITS'(1);
  // XOR masks that turn the active-high internal form into pad polarity; also the "off" levels.
  localparam logic [6:0]          SEG_POL    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                DP_POL     = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [N_DIGITS-1:0] AN_POL     = (DIG_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] val);
    logic [6:0] pattern;
    case (val)
      4'd0:    pattern = 7'h3F;
      4'd1:    pattern = 7'h06;
      4'd2:    pattern = 7'h5B;
      4'd3:    pattern = 7'h4F;
      4'd4:    pattern = 7'h66;
      4'd5:    pattern = 7'h6D;
      4'd6:    pattern = 7'h7D;
      4'd7:    pattern = 7'h07;
      4'd8:    pattern = 7'h7F;
      4'd9:    pattern = 7'h6F;
      4'd10:   pattern = 7'h40;
      default: pattern = 7'h00;
    endcase
    return pattern;
  endfunction

  logic [SW-1:0]         slot_cnt_r;
  logic [DW-1:0]         digit_idx_r;
  logic [FW-1:0]         frame_cnt_r;
  logic                  blink_phase_r;
  logic [4*N_DIGITS-1:0] bcd_snap_r;
  logic [N_DIGITS-1:0]   dp_snap_r;
  logic [N_DIGITS-1:0]   blink_snap_r;
  logic [6:0]            seg_r;
  logic                  dp_r;
  logic [N_DIGITS-1:0]   an_r;
  logic                  frame_tick_r;

  logic                  frame_start_s;
  logic                  slot_wrap_s;
  logic                  frame_wrap_s;
  logic [4*N_DIGITS-1:0] bcd_view_s;
  logic [N_DIGITS-1:0]   dp_view_s;
  logic [N_DIGITS-1:0]   blink_view_s;
  logic [3:0]            cur_bcd_s;
  logic                  lit_s;
  logic [6:0]            seg_on_s;
  logic                  dp_on_s;
  logic [N_DIGITS-1:0]   an_on_s;

  assign frame_start_s = (slot_cnt_r == {SW{1'b0}}) && (digit_idx_r == {DW{1'b0}});
  assign slot_wrap_s   = (slot_cnt_r == SLOT_LAST);
  assign frame_wrap_s  = slot_wrap_s && (digit_idx_r == DIGIT_LAST);

  // Slot, digit, frame and blink counters; a low enable holds the scan at its origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r    <= {SW{1'b0}};
      digit_idx_r   <= {DW{1'b0}};
      frame_cnt_r   <= {FW{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (!enable) begin
      slot_cnt_r    <= {SW{1'b0}};
      digit_idx_r   <= {DW{1'b0}};
      frame_cnt_r   <= {FW{1'b0}};
      blink_phase_r <= 1'b0;
    end else if (slot_wrap_s) begin
      slot_cnt_r <= {SW{1'b0}};
      if (digit_idx_r == DIGIT_LAST) begin
        digit_idx_r <= {DW{1'b0}};
        if (frame_cnt_r == FRAME_LAST) begin
          frame_cnt_r   <= {FW{1'b0}};
          blink_phase_r <= ~blink_phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + 1'b1;
        end
      end else begin
        digit_idx_r <= digit_idx_r + 1'b1;
      end
    end else begin
      slot_cnt_r <= slot_cnt_r + 1'b1;
    end
  end

  // Frame snapshot of the display inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_snap_r   <= {(4*N_DIGITS){1'b0}};
      dp_snap_r    <= {N_DIGITS{1'b0}};
      blink_snap_r <= {N_DIGITS{1'b0}};
    end else if (frame_start_s) begin
      bcd_snap_r   <= digits_bcd;
      dp_snap_r    <= dp_in;
      blink_snap_r <= blink_mask;
    end else begin
      bcd_snap_r   <= bcd_snap_r;
      dp_snap_r    <= dp_snap_r;
      blink_snap_r <= blink_snap_r;
    end
  end

  // Bypass the snapshot in the capture cycle so a zero-length blank window still shows fresh data.
  always_comb begin
    if (frame_start_s) begin
      bcd_view_s   = digits_bcd;
      dp_view_s    = dp_in;
      blink_view_s = blink_mask;
    end else begin
      bcd_view_s   = bcd_snap_r;
      dp_view_s    = dp_snap_r;
      blink_view_s = blink_snap_r;
    end
  end

  // Active-high pattern for the current slot, before pad polarity.
  always_comb begin
    cur_bcd_s = bcd_view_s[{digit_idx_r, 2'b00} +: 4];
    lit_s     = enable && (slot_cnt_r >= BLANK_END)
                && !(blink_phase_r && blink_view_s[digit_idx_r]);
    if (lit_s) begin
      seg_on_s = bcd_to_seg(cur_bcd_s);
      dp_on_s  = dp_view_s[digit_idx_r];
      an_on_s  = AN_ONE << digit_idx_r;
    end else begin
      seg_on_s = 7'h00;
      dp_on_s  = 1'b0;
      an_on_s  = {N_DIGITS{1'b0}};
    end
  end

  // Pad registers, one clock behind the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r        <= SEG_POL;
      dp_r         <= DP_POL;
      an_r         <= AN_POL;
      frame_tick_r <= 1'b0;
    end else begin
      seg_r        <= seg_on_s ^ SEG_POL;
      dp_r         <= dp_on_s ^ DP_POL;
      an_r         <= an_on_s ^ AN_POL;
      frame_tick_r <= enable && frame_wrap_s;
    end
  end

  assign seg        = seg_r;
  assign dp         = dp_r;
  assign an         = an_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: decode table, directed scan/blink/enable/reset
// sequences, and a randomized run against a time-based reference model.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int SDIV  = 8;
  localparam int BLANK = 2;
  localparam int BLINK = 2;
  localparam int FRAME = N * SDIV;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         enable = 1'b0;
  logic [15:0]  digits_bcd = 16'h0000;
  logic [3:0]   dp_in = 4'b0000;
  logic [3:0]   blink_mask = 4'b0000;
  logic [6:0]   seg;
  logic         dp;
  logic [3:0]   an;
  logic         frame_tick;

  seg7_scan_driver #(
    .N_DIGITS(N), .SCAN_DIV(SDIV), .BLANK_CYCLES(BLANK), .BLINK_FRAMES(BLINK),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .digits_bcd(digits_bcd),
    .dp_in(dp_in), .blink_mask(blink_mask), .seg(seg), .dp(dp), .an(an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: enabled clocks since the scan origin, and the frame snapshot.
  int         t = 0;
  int         pre_t = 0;
  logic [15:0] snap_bcd;
  logic [3:0]  snap_dp;
  logic [3:0]  snap_bl;
  logic [6:0]  dec_ref [16];

  typedef struct {
    logic [3:0] val;
    logic [6:0] seg_exp;
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%h required=%h", name, pre_t, act, exp);
    end
  endtask

  // One clock: predict the pins from the model, advance, then compare.
  task automatic step();
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;
    logic       e_ft;
    logic       lit;
    logic       bp;
    int         slot, d, fr;
    pre_t = t;
    if (!enable) begin
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1; e_ft = 1'b0;
      t = 0;
    end else begin
      if (t % FRAME == 0) begin
        snap_bcd = digits_bcd; snap_dp = dp_in; snap_bl = blink_mask;
      end
      slot = t % SDIV;
      d    = (t / SDIV) % N;
      fr   = t / FRAME;
      bp   = ((fr / BLINK) % 2) == 1;
      lit  = (slot >= BLANK) && !(bp && snap_bl[d]);
      e_seg = lit ? ~dec_ref[snap_bcd[d*4 +: 4]] : 7'h7F;
      e_an  = lit ? ~(4'b0001 << d) : 4'hF;
      e_dp  = lit ? ~snap_dp[d] : 1'b1;
      e_ft  = (t % FRAME) == FRAME - 1;
      t++;
    end
    @(posedge clk);
    #1;
    chk("pins{an,seg,dp,tick}", {19'd0, an, seg, dp, frame_tick}, {19'd0, e_an, e_seg, e_dp, e_ft});
    chk("an_at_most_one", {31'd0, ($countones(~an) <= 1)}, 32'd1);
  endtask

  task automatic restart();
    enable = 1'b0;
    step();
  endtask

  int ft_count;
  int lit0 [6];
  logic [6:0] lut [16];

  initial begin
    lut = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    for (int i = 0; i < 16; i++) dec_ref[i] = lut[i];
    tbl = '{'{4'h0, 7'h40}, '{4'h1, 7'h79}, '{4'h2, 7'h24}, '{4'h3, 7'h30},
            '{4'h4, 7'h19}, '{4'h5, 7'h12}, '{4'h6, 7'h02}, '{4'h7, 7'h78},
            '{4'h8, 7'h00}, '{4'h9, 7'h10}, '{4'hA, 7'h3F}, '{4'hB, 7'h7F},
            '{4'hC, 7'h7F}, '{4'hD, 7'h7F}, '{4'hE, 7'h7F}, '{4'hF, 7'h7F}};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {19'd0, an, seg, dp, frame_tick}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;

    // Scan 4321 for two frames, swapping to 9999 while digit 2 is on screen
    digits_bcd = 16'h4321; dp_in = 4'b0000; blink_mask = 4'b0000; enable = 1'b1;
    ft_count = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (t == 2 * SDIV + 3) digits_bcd = 16'h9999;
      step();
      if (frame_tick) ft_count++;
      if (pre_t == 2 * SDIV + 6) chk("hold_digit2", {25'd0, seg}, {25'd0, 7'h30});
      if (pre_t == 3 * SDIV + 6) chk("hold_digit3", {25'd0, seg}, {25'd0, 7'h19});
      if (pre_t == FRAME + 2)    chk("new_frame_9", {25'd0, seg}, {25'd0, 7'h10});
    end
    chk("frame_tick_count", ft_count, 2);

    // Decode table: every BCD code shown on digit 0 right after a restart
    for (int i = 0; i < 16; i++) begin
      restart();
      digits_bcd = {4{tbl[i].val}};
      enable = 1'b1;
      repeat (3) step();
      chk($sformatf("decode_%h", tbl[i].val), {25'd0, seg}, {25'd0, tbl[i].seg_exp});
    end

    // Blink on digit 0 across six frames
    restart();
    digits_bcd = 16'hA05F; blink_mask = 4'b0001; enable = 1'b1;
    for (int f = 0; f < 6; f++) lit0[f] = 0;
    for (int i = 0; i < 6 * FRAME; i++) begin
      step();
      if (an[0] == 1'b0) lit0[pre_t / FRAME]++;
    end
    for (int f = 0; f < 6; f++) chk($sformatf("blink_frame%0d", f), lit0[f], ((f / 2) % 2 == 1) ? 0 : 6);

    // Decimal point on digit 2 only
    restart();
    digits_bcd = 16'h1234; blink_mask = 4'b0000; dp_in = 4'b0100; enable = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      chk("dp_only_digit2", {31'd0, (dp == 1'b0)}, {31'd0, (an == 4'b1011)});
    end

    // Enable drop mid-slot of digit 2, then re-enable
    dp_in = 4'b0000;
    restart();
    enable = 1'b1;
    repeat (2 * SDIV + 4) step();
    enable = 1'b0;
    step();
    chk("disable_pins", {19'd0, an, seg, dp, frame_tick}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    enable = 1'b1;
    repeat (3) step();
    chk("reenable_digit0", {28'd0, an}, {28'd0, 4'b1110});
    repeat (SDIV) step();

    // Async reset mid-slot while blink_phase is 1
    restart();
    blink_mask = 4'b0001; enable = 1'b1;
    repeat (2 * FRAME + 12) step();
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset", {19'd0, an, seg, dp, frame_tick}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;
    t = 0;
    repeat (3) step();
    chk("post_reset_digit0", {28'd0, an}, {28'd0, 4'b1110});
    repeat (FRAME) step();

    // Randomized inputs and occasional enable drops
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) digits_bcd = 16'($urandom);
      if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 19) == 0) blink_mask = 4'($urandom);
      if ($urandom_range(0, 199) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 2) == 0) enable = 1'b1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
